// File: rtl/mul_three_acc_pkg.sv
// Shared types and constants for the product accumulator.
// Build option: MUL_THREE_ACC_SAT_EN clamps the sum instead of wrapping.
package mul_three_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic int cnt_width(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

`ifdef MUL_THREE_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

endpackage

// File: rtl/mul_three_acc_add.sv
// Combinational ACC_W-bit adder with carry-out.
// With SAT set, a carry clamps the sum to all ones.
module mul_three_acc_add #(
    parameter int ACC_W = 10,
    parameter bit SAT   = 1'b0
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0] full;

    // One extra bit catches the carry; clamp or wrap on top of it.
    always_comb begin
        full    = {1'b0, a_i} + {1'b0, b_i};
        carry_o = full[ACC_W];
        if (SAT && full[ACC_W]) begin
            sum_o = '1;
        end else begin
            sum_o = full[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/mul_three_acc.sv
// Groups consecutive products into one wide sum per group.
// Build option: MUL_THREE_ACC_SAT_EN (via the package) selects saturation.
module mul_three_acc
    import mul_three_acc_pkg::*;
#(
    parameter int BW        = 8,
    parameter int ACC_W     = BW + 2,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = cnt_width(MAX_TERMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [BW-1:0]    prod,
    input  logic             prod_last,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] acc_count,
    output logic             acc_ovf
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic [CNT_W-1:0] cnt_inc;
    logic             prod_hs;
    logic             res_hs;

    assign prod_ext = ACC_W'(prod);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    mul_three_acc_add #(
        .ACC_W (ACC_W),
        .SAT   (SAT_EN)
    ) u_add (
        .a_i     (acc_q),
        .b_i     (prod_ext),
        .sum_o   (sum),
        .carry_o (carry)
    );

    // A new product may only enter HOLD while the pending result leaves.
    assign acc_valid  = (state_q == HOLD);
    assign prod_ready = (state_q == ACC) ? 1'b1 : acc_ready;
    assign prod_hs    = prod_valid && prod_ready;
    assign res_hs     = acc_valid && acc_ready;

    assign acc       = acc_q;
    assign acc_count = cnt_q;
    assign acc_ovf   = ovf_q;

    // Next-state: accumulate in ACC, hand off or restart in HOLD.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ACC: begin
                if (prod_hs) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | carry;
                    if (prod_last || (cnt_inc == CNT_W'(MAX_TERMS))) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (res_hs) begin
                    if (prod_hs) begin
                        acc_d = prod_ext;
                        cnt_d = CNT_W'(1);
                        ovf_d = 1'b0;
                        if (prod_last || (MAX_TERMS == 1)) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ACC;
                        end
                    end else begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ACC;
                    end
                end
            end
            default: state_d = ACC;
        endcase
    end

    // State and group registers; reset drops any partial group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mul_three_acc.sv
// Directed bench for mul_three_acc (MAX_TERMS=16 and MAX_TERMS=1).
// Expected sums follow MUL_THREE_ACC_SAT_EN when it is defined.
module tb_mul_three_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prod_valid, prod_last, acc_ready;
    logic [7:0] prod;
    logic       prod_ready, acc_valid, acc_ovf;
    logic [9:0] acc;
    logic [4:0] acc_count;

    logic       prod_valid1, prod_last1, acc_ready1;
    logic [7:0] prod1;
    logic       prod_ready1, acc_valid1, acc_ovf1;
    logic [9:0] acc1;
    logic [0:0] acc_count1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_three_acc #(.BW(8), .ACC_W(10), .MAX_TERMS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .prod_last  (prod_last),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc        (acc),
        .acc_count  (acc_count),
        .acc_ovf    (acc_ovf)
    );

    mul_three_acc #(.BW(8), .ACC_W(10), .MAX_TERMS(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_valid (prod_valid1),
        .prod_ready (prod_ready1),
        .prod       (prod1),
        .prod_last  (prod_last1),
        .acc_valid  (acc_valid1),
        .acc_ready  (acc_ready1),
        .acc        (acc1),
        .acc_count  (acc_count1),
        .acc_ovf    (acc_ovf1)
    );

    // Present one product for one clock; returns at the next falling edge.
    task automatic drive(input logic [7:0] p, input logic last);
        prod_valid = 1'b1;
        prod       = p;
        prod_last  = last;
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({acc_valid, acc, acc_count, acc_ovf} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b acc=%0d cnt=%0d ovf=%0b required all 0",
                     acc_valid, acc, acc_count, acc_ovf);
        end
        n_checks++;
        if (prod_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b required 1", prod_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        acc_ready  = 1'b0;
        prod_last  = 1'b1;
        prod_valid = 1'b0;
        @(negedge clk);
        prod_last  = 1'b0;
        n_checks++;
        if (acc_valid !== 1'b0 || acc_count !== 5'd0) begin
            n_fail++;
            $display("FAIL last_without_valid: got v=%0b cnt=%0d required 0 0",
                     acc_valid, acc_count);
        end
        drive(8'd10, 1'b0);
        drive(8'd20, 1'b0);
        drive(8'd30, 1'b1);
        n_checks++;
        if (acc_valid !== 1'b1 || acc !== 10'd60 || acc_count !== 5'd3 || acc_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_sum: got v=%0b acc=%0d cnt=%0d ovf=%0b required 1 60 3 0",
                     acc_valid, acc, acc_count, acc_ovf);
        end
        n_checks++;
        if (prod_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ready: got %0b required 0", prod_ready);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        n_checks++;
        if (acc_valid !== 1'b0 || acc !== 10'd0 || acc_count !== 5'd0) begin
            n_fail++;
            $display("FAIL basic_drain: got v=%0b acc=%0d cnt=%0d required 0 0 0",
                     acc_valid, acc, acc_count);
        end
    endtask

    task automatic test_forced_close();
        for (int i = 0; i < 16; i++) drive(8'd1, 1'b0);
        n_checks++;
        if (acc_valid !== 1'b1 || acc !== 10'd16 || acc_count !== 5'd16) begin
            n_fail++;
            $display("FAIL forced_close: got v=%0b acc=%0d cnt=%0d required 1 16 16",
                     acc_valid, acc, acc_count);
        end
        prod_valid = 1'b1;
        prod       = 8'd1;
        @(negedge clk);
        n_checks++;
        if (prod_ready !== 1'b0 || acc !== 10'd16 || acc_count !== 5'd16) begin
            n_fail++;
            $display("FAIL forced_hold: got rdy=%0b acc=%0d cnt=%0d required 0 16 16",
                     prod_ready, acc, acc_count);
        end
        prod_valid = 1'b0;
        acc_ready  = 1'b1;
        @(negedge clk);
        acc_ready  = 1'b0;
    endtask

    task automatic test_overflow();
        logic [9:0] exp_acc;
`ifdef MUL_THREE_ACC_SAT_EN
        exp_acc = 10'd1023;
`else
        exp_acc = 10'd251;
`endif
        for (int i = 0; i < 4; i++) drive(8'd255, 1'b0);
        drive(8'd255, 1'b1);
        n_checks++;
        if (acc_valid !== 1'b1 || acc !== exp_acc || acc_count !== 5'd5 || acc_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got v=%0b acc=%0d cnt=%0d ovf=%0b required 1 %0d 5 1",
                     acc_valid, acc, acc_count, acc_ovf, exp_acc);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        n_checks++;
        if (acc_ovf !== 1'b0 || acc !== 10'd0) begin
            n_fail++;
            $display("FAIL overflow_clear: got acc=%0d ovf=%0b required 0 0", acc, acc_ovf);
        end
    endtask

    task automatic test_back_to_back();
        drive(8'd2, 1'b1);
        prod_valid = 1'b1;
        prod       = 8'd7;
        prod_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (acc_valid !== 1'b1 || acc !== 10'd2 || acc_count !== 5'd1 || prod_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d: got v=%0b acc=%0d cnt=%0d rdy=%0b required 1 2 1 0",
                         i, acc_valid, acc, acc_count, prod_ready);
            end
        end
        acc_ready = 1'b1;
        #1;
        n_checks++;
        if (prod_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: got %0b required 1", prod_ready);
        end
        acc_ready = 1'b0;
        #1;
        acc_ready = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        acc_ready  = 1'b0;
        n_checks++;
        if (acc_valid !== 1'b1 || acc !== 10'd7 || acc_count !== 5'd1 || acc_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL handoff: got v=%0b acc=%0d cnt=%0d ovf=%0b required 1 7 1 0",
                     acc_valid, acc, acc_count, acc_ovf);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        n_checks++;
        if (acc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL handoff_drain: got v=%0b required 0", acc_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(8'd50, 1'b0);
        drive(8'd60, 1'b0);
        n_checks++;
        if (acc !== 10'd110 || acc_count !== 5'd2 || acc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_group: got acc=%0d cnt=%0d v=%0b required 110 2 0",
                     acc, acc_count, acc_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({acc_valid, acc, acc_count, acc_ovf} !== 17'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b acc=%0d cnt=%0d ovf=%0b required all 0",
                     acc_valid, acc, acc_count, acc_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'd3, 1'b0);
        drive(8'd4, 1'b1);
        n_checks++;
        if (acc_valid !== 1'b1 || acc !== 10'd7 || acc_count !== 5'd2) begin
            n_fail++;
            $display("FAIL post_reset: got v=%0b acc=%0d cnt=%0d required 1 7 2",
                     acc_valid, acc, acc_count);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    task automatic test_max_one();
        acc_ready1  = 1'b1;
        prod_valid1 = 1'b1;
        prod1       = 8'd5;
        @(negedge clk);
        n_checks++;
        if (acc_valid1 !== 1'b1 || acc1 !== 10'd5 || acc_count1 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_first: got v=%0b acc=%0d cnt=%0d required 1 5 1",
                     acc_valid1, acc1, acc_count1);
        end
        prod1 = 8'd9;
        @(negedge clk);
        prod_valid1 = 1'b0;
        n_checks++;
        if (acc_valid1 !== 1'b1 || acc1 !== 10'd9 || acc_count1 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_second: got v=%0b acc=%0d cnt=%0d required 1 9 1",
                     acc_valid1, acc1, acc_count1);
        end
        @(negedge clk);
        n_checks++;
        if (acc_valid1 !== 1'b0 || acc1 !== 10'd0) begin
            n_fail++;
            $display("FAIL single_drain: got v=%0b acc=%0d required 0 0", acc_valid1, acc1);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        prod_valid  = 1'b0;
        prod_last   = 1'b0;
        prod        = '0;
        acc_ready   = 1'b0;
        prod_valid1 = 1'b0;
        prod_last1  = 1'b0;
        prod1       = '0;
        acc_ready1  = 1'b0;
        test_reset();
        test_basic();
        test_forced_close();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_max_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_three_acc.md
Name: mul_three_acc

Overview:
Downstream consumer of the three-operand multiplier's BW-bit product. Accumulates a group of consecutive products into a wider sum and emits one result per group. Uses valid/ready handshakes on both sides. Groups are closed by an explicit last marker or by reaching a term-count limit.

Parameters:
BW, 8, product width; matches the upstream multiplier's BW.
ACC_W, BW+2, accumulator/result width; must be >= BW.
MAX_TERMS, 16, maximum products per group; reaching it forces the group closed; must be >= 1.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
prod_valid  in  1  upstream product is valid.
prod_ready  out  1  block accepts a product this cycle.
prod  in  BW  product from the multiplier; unsigned.
prod_last  in  1  qualifies prod; this product is the final one of its group.
acc_valid  out  1  result is valid.
acc_ready  in  1  downstream accepts the result.
acc  out  ACC_W  group sum.
acc_count  out  CNT_W  number of products in the group; CNT_W = $clog2(MAX_TERMS+1).
acc_ovf  out  1  sticky flag: the sum exceeded 2^ACC_W-1 at some point during the group.

Behaviour:
- Handshakes:
  - Product handshake: prod_valid && prod_ready.
  - Result handshake: acc_valid && acc_ready.
  - Once acc_valid is asserted, acc, acc_count and acc_ovf stay stable until the result handshake.
- State machine, two states: ACC (collecting) and HOLD (result pending).
- Reset (asynchronous, rst_n low): state=ACC, acc=0, acc_count=0, acc_ovf=0, acc_valid=0. Any partial group is discarded. Release is clean; the first product after reset starts a new group.
- ACC state:
  - prod_ready=1, acc_valid=0.
  - On a product handshake: acc <= acc + zero-extended prod (wrap rule below); acc_count <= acc_count+1; acc_ovf |= carry-out.
  - If prod_last=1, or the new acc_count equals MAX_TERMS, go to HOLD next cycle.
- HOLD state:
  - acc_valid=1.
  - prod_ready=acc_ready, so accepting a new product is allowed only in the same cycle the result leaves.
  - Result handshake without a product handshake: go to ACC; acc, acc_count, acc_ovf clear to 0.
  - Result handshake together with a product handshake: the new product starts the next group. acc <= prod, acc_count <= 1, acc_ovf <= 0. Stay in HOLD if that product has prod_last=1 or MAX_TERMS=1; otherwise go to ACC. No product is lost and no bubble is inserted.
  - acc_ready=0: hold all outputs; prod_ready=0.
- Latency: acc_valid rises the cycle after the closing product handshake. Throughput is one product per cycle.
- Arithmetic: unsigned only. The sum is computed at ACC_W+1 bits; the MSB is the overflow carry. Default behaviour wraps modulo 2^ACC_W.
- prod_last is ignored unless prod_valid=1.
- MAX_TERMS=1: every product forms a group of its own.

Optional Feature:
MUL_THREE_ACC_SAT_EN
- Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the group; acc_ovf still sets.
- Undefined: acc wraps modulo 2^ACC_W; acc_ovf still sets.
- Handshake and timing are identical in both builds.

Decomposition:
- Package mul_three_acc_pkg holds:
  - state enum (ACC, HOLD);
  - function for CNT_W from MAX_TERMS;
  - saturation/wrap select constant derived from the macro.
- One small sub-module is natural: mul_three_acc_add. It is a combinational ACC_W-bit adder with carry-out and optional clamp, and is unit-tested separately. The FSM and registers stay in the top module.

Test Plan:
(BW=8, ACC_W=10, MAX_TERMS=16 unless noted.)
- Products 10, 20, 30, with last on 30 -> one cycle later acc_valid=1, acc=60, acc_count=3, acc_ovf=0.
- Sixteen products of 1, never last -> forced close: acc=16, acc_count=16; prod_ready drops while unaccepted.
- Five products of 255, last on the 5th:
  - without MUL_THREE_ACC_SAT_EN -> acc=251, acc_ovf=1, acc_count=5;
  - with it -> acc=1023, acc_ovf=1.
- Result pending, acc_ready=0 for 5 cycles with prod_valid=1 (prod=7) -> outputs stable, prod_ready=0. Then acc_ready=1 -> result leaves, 7 accepted the same cycle, next group result acc=7 after closing.
- rst_n asserted after 2 products mid-group -> all outputs 0 immediately. After release, products 3, 4 with last -> acc=7, acc_count=2.
- MAX_TERMS=1, back-to-back products 5, 9 with acc_ready=1 -> acc_valid on consecutive cycles, acc=5 then 9, acc_count=1 each.
